// File: rtl/types.sv
// Shared DCF77 types: BCD digit, decoded date/time payload, telegram bit map and FSM states.
package types;

    typedef logic [3:0] bcd_t;

    localparam int unsigned CNT_W         = 8;
    localparam int unsigned BIT_CNT_W     = 6;
    localparam int unsigned TELEGRAM_BITS = 59;

    localparam int unsigned START_BIT  = 0;
    localparam int unsigned TIME_START = 20;
    localparam int unsigned MIN_LSB    = 21;
    localparam int unsigned P1         = 28;
    localparam int unsigned HOUR_LSB   = 29;
    localparam int unsigned P2         = 35;
    localparam int unsigned DAY_LSB    = 36;
    localparam int unsigned DOW_LSB    = 42;
    localparam int unsigned MONTH_LSB  = 45;
    localparam int unsigned YEAR_LSB   = 50;
    localparam int unsigned P3         = 58;

    typedef enum logic {
        HUNT,
        RECV
    } dcf77_state_t;

    typedef struct packed {
        bcd_t [1:0] year;
        bcd_t [1:0] month;
        bcd_t [1:0] day;
        logic [2:0] dow;
        bcd_t [1:0] hour;
        bcd_t [1:0] minute;
    } dcf77_time_t;

    localparam dcf77_time_t DCF77_TIME_RESET = '{
        year:   8'h00,
        month:  8'h01,
        day:    8'h01,
        dow:    3'd1,
        hour:   8'h00,
        minute: 8'h00
    };

    function automatic logic digit_ok(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/dcf77_decoder_if.sv
// Decoded DCF77 date/time bundle handed to the downstream clock stage.
interface dcf77_decoder_if;
    import types::*;

    logic       dcf77_sync;
    bcd_t [1:0] dcf77_year;
    bcd_t [1:0] dcf77_month;
    bcd_t [1:0] dcf77_day;
    logic [2:0] dcf77_day_of_week;
    bcd_t [1:0] dcf77_hour;
    bcd_t [1:0] dcf77_minute;
    logic       locked;

    modport master (
        output dcf77_sync, dcf77_year, dcf77_month, dcf77_day,
               dcf77_day_of_week, dcf77_hour, dcf77_minute, locked
    );

    modport slave (
        input  dcf77_sync, dcf77_year, dcf77_month, dcf77_day,
               dcf77_day_of_week, dcf77_hour, dcf77_minute, locked
    );

endinterface

// File: rtl/dcf77_telegram_check.sv
// Combinational decode and plausibility check of a stored 59-bit DCF77 minute telegram.
module dcf77_telegram_check
    import types::*;
(
    input  logic [TELEGRAM_BITS-1:0] telegram,
    output logic                     valid_c,
    output dcf77_time_t              fields_c
);

    logic p1_ok_c;
    logic p2_ok_c;
    logic p3_ok_c;
    logic unused_civil_bits;

    // Bits 1..19 carry weather/civil-warning data that this clock ignores.
    assign unused_civil_bits = ^telegram[TIME_START-1:START_BIT+1];

    always_comb begin
        fields_c        = DCF77_TIME_RESET;
        fields_c.minute = {1'b0, telegram[MIN_LSB+4 +: 3], telegram[MIN_LSB +: 4]};
        fields_c.hour   = {2'b00, telegram[HOUR_LSB+4 +: 2], telegram[HOUR_LSB +: 4]};
        fields_c.day    = {2'b00, telegram[DAY_LSB+4 +: 2], telegram[DAY_LSB +: 4]};
        fields_c.dow    = telegram[DOW_LSB +: 3];
        fields_c.month  = {3'b000, telegram[MONTH_LSB+4], telegram[MONTH_LSB +: 4]};
        fields_c.year   = telegram[YEAR_LSB +: 8];
    end

    // Even parity: each group including its parity bit holds an even number of ones.
    assign p1_ok_c = ~^telegram[P1:MIN_LSB];
    assign p2_ok_c = ~^telegram[P2:HOUR_LSB];
    assign p3_ok_c = ~^telegram[P3:DAY_LSB];

    always_comb begin
        valid_c = !telegram[START_BIT] && telegram[TIME_START]
               && p1_ok_c && p2_ok_c && p3_ok_c
               && digit_ok(fields_c.minute[0]) && (fields_c.minute[1] <= 4'd5)
               && digit_ok(fields_c.hour[0])
               && ((fields_c.hour[1] < 4'd2)
                   || ((fields_c.hour[1] == 4'd2) && (fields_c.hour[0] <= 4'd3)))
               && digit_ok(fields_c.day[0]) && (fields_c.day != 8'h00)
               && ((fields_c.day[1] < 4'd3)
                   || ((fields_c.day[1] == 4'd3) && (fields_c.day[0] <= 4'd1)))
               && (fields_c.dow != 3'd0)
               && digit_ok(fields_c.month[0]) && (fields_c.month != 8'h00)
               && ((fields_c.month[1] == 4'd0) || (fields_c.month[0] <= 4'd2))
               && digit_ok(fields_c.year[0]) && digit_ok(fields_c.year[1]);
    end

endmodule

// File: rtl/dcf77_decoder.sv
// DCF77 pulse-width classifier and minute-telegram assembler; publishes date/time
// with a one-tick sync pulse on the minute-marker rise of each valid telegram.
module dcf77_decoder
    import types::*;
#(
    parameter int unsigned T0_MIN   = 6,
    parameter int unsigned T0_MAX   = 14,
    parameter int unsigned T1_MIN   = 15,
    parameter int unsigned T1_MAX   = 25,
    parameter int unsigned GAP_MIN  = 60,
    parameter int unsigned GAP_MAX  = 100,
    parameter int unsigned MARK_MIN = 150,
    parameter int unsigned MARK_MAX = 220
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_en,
    input  logic           rx,
    dcf77_decoder_if.master dcf
);

    dcf77_state_t               state_q, state_d;
    logic                       rx_q;
    logic [CNT_W-1:0]           high_cnt, low_cnt, high_d, low_d;
    logic [BIT_CNT_W-1:0]       bit_cnt, bit_cnt_d;
    logic [TELEGRAM_BITS-1:0]   telegram_q, telegram_d;
    logic                       sync_q, sync_d;
    logic                       locked_q, locked_d;
    dcf77_time_t                time_q, time_d;

    logic                       rise_c, fall_c;
    logic                       is_zero_c, is_one_c, gap_c, mark_c, lost_c, err_c;
    logic                       tele_valid_c;
    dcf77_time_t                tele_time_c;

    function automatic logic in_range(input logic [CNT_W-1:0] v, lo, hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    dcf77_telegram_check u_check (
        .telegram (telegram_q),
        .valid_c  (tele_valid_c),
        .fields_c (tele_time_c)
    );

    // Edge detection and level-width counters; the edge tick counts toward the new level.
    always_comb begin
        rise_c = rx & ~rx_q;
        fall_c = ~rx & rx_q;
        high_d = high_cnt;
        low_d  = low_cnt;
        if (rise_c) begin
            high_d = CNT_W'(1);
            low_d  = '0;
        end else if (fall_c) begin
            high_d = '0;
            low_d  = CNT_W'(1);
        end else if (rx) begin
            high_d = sat_inc(high_cnt);
        end else begin
            low_d  = sat_inc(low_cnt);
        end
    end

    always_comb begin
        is_zero_c = in_range(high_cnt, CNT_W'(T0_MIN), CNT_W'(T0_MAX));
        is_one_c  = in_range(high_cnt, CNT_W'(T1_MIN), CNT_W'(T1_MAX));
        gap_c     = in_range(low_cnt, CNT_W'(GAP_MIN), CNT_W'(GAP_MAX));
        mark_c    = in_range(low_cnt, CNT_W'(MARK_MIN), CNT_W'(MARK_MAX));
        lost_c    = ~rx & (low_d > CNT_W'(MARK_MAX));
    end

    // Next-state and output logic; nothing moves except on a tick.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt;
        telegram_d = telegram_q;
        sync_d     = sync_q;
        locked_d   = locked_q;
        time_d     = time_q;
        err_c      = 1'b0;

        if (clk_en) begin
            sync_d = 1'b0;
            case (state_q)
                HUNT: begin
                    if (rise_c && mark_c) begin
                        bit_cnt_d = '0;
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    if (fall_c) begin
                        if ((bit_cnt == BIT_CNT_W'(TELEGRAM_BITS)) || !(is_zero_c || is_one_c)) begin
                            err_c = 1'b1;
                        end else begin
                            telegram_d[bit_cnt] = is_one_c;
                            bit_cnt_d           = bit_cnt + BIT_CNT_W'(1);
                        end
                    end else if (rise_c) begin
                        if (mark_c) begin
                            if ((bit_cnt == BIT_CNT_W'(TELEGRAM_BITS)) && tele_valid_c) begin
                                sync_d   = 1'b1;
                                time_d   = tele_time_c;
                                locked_d = 1'b1;
                            end else begin
                                locked_d = 1'b0;
                            end
                            bit_cnt_d = '0;
                        end else if (!gap_c) begin
                            err_c = 1'b1;
                        end
                    end else if (lost_c) begin
                        err_c = 1'b1;
                    end

                    if (err_c) begin
                        locked_d = 1'b0;
                        state_d  = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            rx_q       <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            bit_cnt    <= '0;
            telegram_q <= '0;
            sync_q     <= 1'b0;
            locked_q   <= 1'b0;
            time_q     <= DCF77_TIME_RESET;
        end else begin
            if (clk_en) begin
                rx_q     <= rx;
                high_cnt <= high_d;
                low_cnt  <= low_d;
            end
            state_q    <= state_d;
            bit_cnt    <= bit_cnt_d;
            telegram_q <= telegram_d;
            sync_q     <= sync_d;
            locked_q   <= locked_d;
            time_q     <= time_d;
        end
    end

    assign dcf.dcf77_sync        = sync_q;
    assign dcf.dcf77_year        = time_q.year;
    assign dcf.dcf77_month       = time_q.month;
    assign dcf.dcf77_day         = time_q.day;
    assign dcf.dcf77_day_of_week = time_q.dow;
    assign dcf.dcf77_hour        = time_q.hour;
    assign dcf.dcf77_minute      = time_q.minute;
    assign dcf.locked            = locked_q;

endmodule
